// File: rtl/printer_fifo.sv
// Byte FIFO between the Z80 printer port (OUT/IN 0xF8) and the ESP SPI drain path.
// Raises data_ready once enough bytes are queued or the host has gone quiet.
module printer_fifo #(
  parameter int DEPTH     = 16,
  parameter int THRESHOLD = 8,
  parameter int TIMEOUT   = 84000
) (
  input  logic                     clk,
  input  logic                     srst,
  input  logic                     wr_strobe,
  input  logic [7:0]               wr_data,
  input  logic                     rd_strobe,
  output logic [7:0]               rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full,
  output logic [7:0]               status,
  output logic                     data_ready,
  output logic                     overflow,
  input  logic                     clr_overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TIMEOUT_V = TW'(TIMEOUT);
  localparam logic [CW-1:0] THRESH_V  = CW'(THRESHOLD);
  localparam logic [CW-1:0] DEPTH_V   = CW'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_READY = 2'd2
  } state_t;

  logic [7:0]    mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  state_t        state_r;
  state_t        state_s;
  logic [TW-1:0] timer_r;
  logic [TW-1:0] timer_s;
  logic          push_s;
  logic          pop_s;
  logic          drop_s;
  logic [CW-1:0] count_s;

  // Accept/drop decision; a pop in the same cycle frees the slot a full FIFO needs
  always_comb begin
    push_s  = 1'b0;
    drop_s  = 1'b0;
    pop_s   = rd_strobe & ~empty;
    if (wr_strobe) begin
      if (!full || rd_strobe) begin
        push_s = 1'b1;
      end else begin
        drop_s = 1'b1;
      end
    end else begin
      push_s = 1'b0;
      drop_s = 1'b0;
    end
    count_s = count + CW'(push_s) - CW'(pop_s);
  end

  // Storage array; contents are not reset, the pointers define validity
  always_ff @(posedge clk) begin
    if (!srst && push_s) begin
      mem_r[wr_ptr_r] <= wr_data;
    end
  end

  // Pointers, fill level, read data and sticky overflow
  always_ff @(posedge clk) begin
    if (srst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count    <= '0;
      empty    <= 1'b1;
      full     <= 1'b0;
      rd_data  <= 8'h00;
      overflow <= 1'b0;
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + AW'(1);
      if (pop_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
      count <= count_s;
      empty <= (count_s == CW'(0));
      full  <= (count_s == DEPTH_V);
      if (rd_strobe) rd_data <= empty ? 8'h00 : mem_r[rd_ptr_r];
      if (drop_s) begin
        overflow <= 1'b1;
      end else if (clr_overflow) begin
        overflow <= 1'b0;
      end
    end
  end

  // Drain-request next state and idle timer
  always_comb begin
    state_s = state_r;
    timer_s = timer_r;
    case (state_r)
      ST_IDLE: begin
        if (push_s) begin
          state_s = ST_FILL;
          timer_s = TIMEOUT_V;
        end else begin
          state_s = ST_IDLE;
          timer_s = '0;
        end
      end
      ST_FILL: begin
        if (push_s) begin
          timer_s = TIMEOUT_V;
        end else if (timer_r != '0) begin
          timer_s = timer_r - TW'(1);
        end else begin
          timer_s = '0;
        end
        if (count_s == CW'(0)) begin
          state_s = ST_IDLE;
        end else if (count_s >= THRESH_V || timer_r == '0) begin
          state_s = ST_READY;
        end else begin
          state_s = ST_FILL;
        end
      end
      ST_READY: begin
        timer_s = '0;
        if (count_s == CW'(0)) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_READY;
        end
      end
      default: begin
        state_s = ST_IDLE;
        timer_s = '0;
      end
    endcase
  end

  // Drain-request state register; data_ready tracks the state being entered
  always_ff @(posedge clk) begin
    if (srst) begin
      state_r    <= ST_IDLE;
      timer_r    <= '0;
      data_ready <= 1'b0;
    end else begin
      state_r    <= state_s;
      timer_r    <= timer_s;
      data_ready <= (state_s == ST_READY);
    end
  end

  assign status = {full, 1'b0, 1'b1, 1'b1, 4'b0000};

endmodule

// File: tb/tb_printer_fifo.sv
// Directed-vector bench for printer_fifo (DEPTH 16, THRESHOLD 8, TIMEOUT 100).
module tb_printer_fifo;

  logic       clk = 1'b0;
  logic       srst;
  logic       wr_strobe;
  logic [7:0] wr_data;
  logic       rd_strobe;
  logic       clr_overflow;
  logic [7:0] rd_data;
  logic [4:0] count;
  logic       empty;
  logic       full;
  logic [7:0] status;
  logic       data_ready;
  logic       overflow;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  printer_fifo #(.DEPTH(16), .THRESHOLD(8), .TIMEOUT(100)) dut (
    .clk(clk), .srst(srst), .wr_strobe(wr_strobe), .wr_data(wr_data),
    .rd_strobe(rd_strobe), .rd_data(rd_data), .count(count), .empty(empty),
    .full(full), .status(status), .data_ready(data_ready), .overflow(overflow),
    .clr_overflow(clr_overflow)
  );

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d);
    wr_strobe = 1'b1;
    wr_data   = d;
    tick();
    wr_strobe = 1'b0;
  endtask

  task automatic pop();
    rd_strobe = 1'b1;
    tick();
    rd_strobe = 1'b0;
  endtask

  task automatic push_pop(input logic [7:0] d);
    wr_strobe = 1'b1;
    rd_strobe = 1'b1;
    wr_data   = d;
    tick();
    wr_strobe = 1'b0;
    rd_strobe = 1'b0;
  endtask

  initial begin
    bit seen;
    srst = 1'b1; wr_strobe = 1'b0; rd_strobe = 1'b0; clr_overflow = 1'b0; wr_data = 8'h00;
    tick(); tick();
    srst = 1'b0;
    tick();

    // reset state
    check_eq("rst_count", 32'(count), 0);
    check_eq("rst_empty", 32'(empty), 1);
    check_eq("rst_full", 32'(full), 0);
    check_eq("rst_rd_data", 32'(rd_data), 0);
    check_eq("rst_ovf", 32'(overflow), 0);
    check_eq("rst_ready", 32'(data_ready), 0);
    check_eq("rst_status", 32'(status), 'h30);

    // basic ordering, hold, read-while-empty
    push(8'h41); push(8'h42); push(8'h43);
    check_eq("abc_count", 32'(count), 3);
    pop(); check_eq("abc_rd0", 32'(rd_data), 'h41);
    pop(); check_eq("abc_rd1", 32'(rd_data), 'h42);
    pop(); check_eq("abc_rd2", 32'(rd_data), 'h43);
    check_eq("abc_empty", 32'(empty), 1);
    tick(); tick();
    check_eq("rd_hold", 32'(rd_data), 'h43);
    pop();
    check_eq("rd_empty_zero", 32'(rd_data), 0);
    check_eq("rd_empty_count", 32'(count), 0);

    // fill, overflow, set-wins-over-clear, drain, clear
    for (int i = 0; i < 16; i++) push(8'(i));
    check_eq("full_flag", 32'(full), 1);
    check_eq("full_count", 32'(count), 16);
    check_eq("full_status", 32'(status), 'hB0);
    check_eq("full_ready", 32'(data_ready), 1);
    push(8'hFF);
    check_eq("ovf_set", 32'(overflow), 1);
    check_eq("ovf_count", 32'(count), 16);
    clr_overflow = 1'b1;
    push(8'hEE);
    clr_overflow = 1'b0;
    check_eq("ovf_set_wins", 32'(overflow), 1);
    for (int i = 0; i < 16; i++) begin
      pop();
      check_eq("full_drain", 32'(rd_data), i);
    end
    check_eq("drain_empty", 32'(empty), 1);
    clr_overflow = 1'b1; tick(); clr_overflow = 1'b0;
    check_eq("ovf_clr", 32'(overflow), 0);
    check_eq("drain_ready", 32'(data_ready), 0);

    // threshold
    for (int i = 0; i < 7; i++) push(8'h80 + 8'(i));
    check_eq("thr_below", 32'(data_ready), 0);
    push(8'h87);
    seen = data_ready;
    tick(); seen |= data_ready;
    tick(); seen |= data_ready;
    check_eq("thr_ready", 32'(seen), 1);
    for (int i = 0; i < 7; i++) begin
      pop();
      check_eq("thr_drain", 32'(rd_data), 'h80 + i);
    end
    check_eq("thr_persist", 32'(data_ready), 1);
    pop();
    check_eq("thr_last", 32'(rd_data), 'h87);
    tick();
    check_eq("thr_idle", 32'(data_ready), 0);

    // timeout from a single write
    push(8'h55);
    seen = 1'b0;
    for (int i = 0; i < 99; i++) begin tick(); seen |= data_ready; end
    check_eq("to_early", 32'(seen), 0);
    seen = 1'b0;
    for (int i = 0; i < 3; i++) begin tick(); seen |= data_ready; end
    check_eq("to_ready", 32'(seen), 1);
    pop();
    check_eq("to_rd", 32'(rd_data), 'h55);
    tick();
    check_eq("to_idle", 32'(data_ready), 0);

    // a second write restarts the wait
    push(8'h61);
    for (int i = 0; i < 49; i++) tick();
    push(8'h62);
    seen = 1'b0;
    for (int i = 0; i < 99; i++) begin tick(); seen |= data_ready; end
    check_eq("to_restart_early", 32'(seen), 0);
    seen = 1'b0;
    for (int i = 0; i < 3; i++) begin tick(); seen |= data_ready; end
    check_eq("to_restart_ready", 32'(seen), 1);
    pop(); check_eq("to_rd61", 32'(rd_data), 'h61);
    pop(); check_eq("to_rd62", 32'(rd_data), 'h62);

    // simultaneous write/read on a full FIFO
    for (int i = 0; i < 16; i++) push(8'hA0 + 8'(i));
    push_pop(8'h99);
    check_eq("sim_full_rd", 32'(rd_data), 'hA0);
    check_eq("sim_full_count", 32'(count), 16);
    check_eq("sim_full_ovf", 32'(overflow), 0);
    for (int i = 1; i < 16; i++) begin
      pop();
      check_eq("sim_full_drain", 32'(rd_data), 'hA0 + i);
    end
    pop();
    check_eq("sim_full_last", 32'(rd_data), 'h99);
    check_eq("sim_full_empty", 32'(empty), 1);

    // simultaneous mid-level and empty
    push(8'h21); push(8'h22);
    push_pop(8'h23);
    check_eq("sim_mid_rd", 32'(rd_data), 'h21);
    check_eq("sim_mid_count", 32'(count), 2);
    pop(); check_eq("sim_mid_rd2", 32'(rd_data), 'h22);
    pop(); check_eq("sim_mid_rd3", 32'(rd_data), 'h23);
    push_pop(8'h24);
    check_eq("sim_empty_rd", 32'(rd_data), 0);
    check_eq("sim_empty_count", 32'(count), 1);
    pop(); check_eq("sim_empty_data", 32'(rd_data), 'h24);

    // pointer wrap-around
    for (int i = 0; i < 40; i++) begin
      push(8'h10 + 8'(i));
      pop();
      check_eq("wrap", 32'(rd_data), 'h10 + i);
    end

    // reset priority over a write with data queued
    for (int i = 0; i < 5; i++) push(8'hC0 + 8'(i));
    check_eq("pre_rst_count", 32'(count), 5);
    srst = 1'b1;
    push(8'h77);
    srst = 1'b0;
    check_eq("srst_count", 32'(count), 0);
    check_eq("srst_empty", 32'(empty), 1);
    check_eq("srst_ready", 32'(data_ready), 0);
    check_eq("srst_rd", 32'(rd_data), 0);
    pop();
    check_eq("srst_discard", 32'(rd_data), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/printer_fifo.md
PRINTER_FIFO -- requirements
Module: printer_fifo

Interface
REQ-001 SHALL provide parameter DEPTH, default 16, meaning FIFO entries (power of two, 4..256).
REQ-002 SHALL provide parameter THRESHOLD, default 8, meaning fill level at which data_ready asserts immediately.
REQ-003 SHALL provide parameter TIMEOUT, default 84000, meaning idle cycles after the last accepted write before data_ready asserts (1 ms at 84 MHz).
REQ-004 SHALL have one clock; reset is synchronous and active-high.
REQ-005 clk  input  1  system clock, 84 MHz.
REQ-006 srst  input  1  synchronous active-high reset.
REQ-007 wr_strobe  input  1  one-cycle pulse per Z80 OUT to printer data port 0xF8.
REQ-008 wr_data  input  8  Z80 data byte, valid with wr_strobe.
REQ-009 rd_strobe  input  1  one-cycle pulse per SPI get_printer_byte command.
REQ-010 rd_data  output  8  popped byte, registered.
REQ-011 count  output  log2(DEPTH)+1  current fill level.
REQ-012 empty / full  output  1 each  count==0 / count==DEPTH.
REQ-013 status  output  8  Z80 printer status byte for IN 0xF8.
REQ-014 data_ready  output  1  level request to ESP to drain FIFO.
REQ-015 overflow  output  1  sticky dropped-byte flag.
REQ-016 clr_overflow  input  1  one-cycle pulse clearing overflow.

Function
REQ-017 Storage SHALL be circular, write and read pointers log2(DEPTH) bits, wrapping DEPTH-1 -> 0.
REQ-018 wr_strobe with full=0 SHALL store wr_data at write pointer; count/full/empty updated next cycle.
REQ-019 wr_strobe with full=1 and rd_strobe=0 SHALL drop the byte and set overflow next cycle.
REQ-020 rd_strobe with empty=0 SHALL load head byte into rd_data one cycle later and advance read pointer.
REQ-021 rd_strobe with empty=1 SHALL load rd_data=8'h00, pointers/count unchanged.
REQ-022 Simultaneous wr_strobe and rd_strobe with 0<count<DEPTH: both performed, count unchanged.
REQ-023 Simultaneous with full=1: pop first, write accepted, count stays DEPTH, overflow not set.
REQ-024 Simultaneous with empty=1: write accepted, rd_data=8'h00, count becomes 1.
REQ-025 rd_data SHALL hold its value between rd_strobes.
REQ-026 status SHALL be {full, 1'b0 (paper ok), 1'b1 (selected), 1'b1 (no fault), 4'b0000}, combinational from full.
REQ-027 overflow SHALL set per REQ-019 and clear on clr_overflow; simultaneous set and clear: set wins.
REQ-028 Drain FSM states: IDLE (empty), FILL (non-empty, waiting), READY (data_ready=1).
REQ-029 IDLE -> FILL on accepted write; timer loaded with TIMEOUT.
REQ-030 FILL: every accepted write reloads timer; otherwise timer decrements by 1 per cycle.
REQ-031 FILL -> READY when count >= THRESHOLD or timer reaches 0.
REQ-032 READY -> IDLE when count becomes 0; READY SHALL persist while count>0 regardless of writes.
REQ-033 FILL -> IDLE if count becomes 0 by reads before threshold/timeout.
REQ-034 data_ready SHALL be registered, high exactly in READY.
REQ-035 Timer SHALL be wide enough for TIMEOUT, never underflow below 0.

Reset
REQ-036 srst SHALL clear pointers, count=0, empty=1, full=0, rd_data=8'h00, overflow=0, data_ready=0, FSM=IDLE, timer=0.
REQ-037 srst SHALL take priority over wr_strobe, rd_strobe and clr_overflow in the same cycle; stored bytes are discarded.

Verification
REQ-038 Write 0x41,0x42,0x43 then 3 rd_strobes -> rd_data 0x41,0x42,0x43 each one cycle after strobe; empty=1 after.
REQ-039 16 writes (0x00..0x0F) then write 0xFF -> full=1, status=8'hB0, overflow=1; 16 reads return 0x00..0x0F; clr_overflow -> overflow=0.
REQ-040 8 writes, THRESHOLD=8 -> data_ready=1 within 2 cycles of 8th write; 8 reads -> data_ready=0 after count hits 0.
REQ-041 TIMEOUT=100: 1 write, no reads -> data_ready=0 through cycle 99, =1 by cycle 102; second write at cycle 50 restarts wait.
REQ-042 Full FIFO plus simultaneous wr/rd of 0x99 -> count=16, overflow=0, 0x99 read last; wrap-around verified by 40 interleaved writes/reads.
REQ-043 srst asserted with count=5 and wr_strobe high -> count=0, empty=1, data_ready=0, rd_data=0x00 next cycle.
